// File: rtl/cc_pos_downcounter.sv
// ---------------------------------------------------------------------------
// cc_pos_downcounter
//   Loadable down-counter with a start/abort FSM. A preset is loaded on an
//   accepted start, counted down to zero on tick pulses while running, and
//   completion is flagged by a one-cycle done pulse. With auto-reload enabled
//   the stored preset is reloaded after DONE so the counter runs periodically.
//
// Ports
//   CC_posDOWNCOUNTER_CLOCK_50      in   system clock, rising edge
//   CC_posDOWNCOUNTER_RESET_InLow   in   asynchronous reset, active-low
//   CC_posDOWNCOUNTER_start_In      in   load preset and begin counting
//   CC_posDOWNCOUNTER_abort_In      in   stop, clear count, return to IDLE
//   CC_posDOWNCOUNTER_tick_In       in   count-enable pulse (used only in RUN)
//   CC_posDOWNCOUNTER_data_InBUS    in   preset value, sampled on accepted start
//   CC_posDOWNCOUNTER_data_OutBUS   out  current count (registered)
//   CC_posDOWNCOUNTER_T0_OutLow     out  0 when count==0, else 1 (registered)
//   CC_posDOWNCOUNTER_busy_Out      out  1 while in RUN
//   CC_posDOWNCOUNTER_done_OutPulse out  1 for the single cycle spent in DONE
// ---------------------------------------------------------------------------
module cc_pos_downcounter #(
  parameter int posDOWNCOUNTER_DATAWIDTH  = 3,
  parameter bit posDOWNCOUNTER_AUTORELOAD = 1'b0
) (
  input  logic                                CC_posDOWNCOUNTER_CLOCK_50,
  input  logic                                CC_posDOWNCOUNTER_RESET_InLow,
  input  logic                                CC_posDOWNCOUNTER_start_In,
  input  logic                                CC_posDOWNCOUNTER_abort_In,
  input  logic                                CC_posDOWNCOUNTER_tick_In,
  input  logic [posDOWNCOUNTER_DATAWIDTH-1:0] CC_posDOWNCOUNTER_data_InBUS,
  output logic [posDOWNCOUNTER_DATAWIDTH-1:0] CC_posDOWNCOUNTER_data_OutBUS,
  output logic                                CC_posDOWNCOUNTER_T0_OutLow,
  output logic                                CC_posDOWNCOUNTER_busy_Out,
  output logic                                CC_posDOWNCOUNTER_done_OutPulse
);

  localparam int W = posDOWNCOUNTER_DATAWIDTH;
  localparam logic [W-1:0] oneVal  = W'(1);
  localparam logic [W-1:0] zeroVal = '0;

  typedef enum logic [1:0] {
    stIdle = 2'd0,
    stRun  = 2'd1,
    stDone = 2'd2
  } stateT;

  stateT          stateReg, stateNext;
  logic [W-1:0]   countReg, countNext;
  logic [W-1:0]   shadowReg, shadowNext;
  logic           t0Reg;

  // State, count, shadow preset and zero flag share one register stage so the
  // zero flag always matches the count visible in the same cycle.
  always_ff @(posedge CC_posDOWNCOUNTER_CLOCK_50 or negedge CC_posDOWNCOUNTER_RESET_InLow) begin
    if (!CC_posDOWNCOUNTER_RESET_InLow) begin
      stateReg  <= stIdle;
      countReg  <= zeroVal;
      shadowReg <= zeroVal;
      t0Reg     <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      countReg  <= countNext;
      shadowReg <= shadowNext;
      t0Reg     <= (countNext != zeroVal);
    end
  end

  always_comb begin
    stateNext  = stateReg;
    countNext  = countReg;
    shadowNext = shadowReg;

    unique case (stateReg)
      stIdle: begin
        // tick is ignored here, so a tick coincident with start is discarded
        if (CC_posDOWNCOUNTER_abort_In) begin
          stateNext = stIdle;
          countNext = zeroVal;
        end else if (CC_posDOWNCOUNTER_start_In) begin
          countNext  = CC_posDOWNCOUNTER_data_InBUS;
          shadowNext = CC_posDOWNCOUNTER_data_InBUS;
          stateNext  = (CC_posDOWNCOUNTER_data_InBUS != zeroVal) ? stRun : stDone;
        end
      end

      stRun: begin
        // start is deliberately not checked: a running count is never restarted
        if (CC_posDOWNCOUNTER_abort_In) begin
          stateNext = stIdle;
          countNext = zeroVal;
        end else if (CC_posDOWNCOUNTER_tick_In) begin
          if (countReg > oneVal) begin
            countNext = countReg - oneVal;
          end else begin
            // last step: reaching zero and entering DONE happen on the same edge
            countNext = zeroVal;
            stateNext = stDone;
          end
        end
      end

      stDone: begin
        if (CC_posDOWNCOUNTER_abort_In) begin
          stateNext = stIdle;
          countNext = zeroVal;
        end else if (CC_posDOWNCOUNTER_start_In) begin
          countNext  = CC_posDOWNCOUNTER_data_InBUS;
          shadowNext = CC_posDOWNCOUNTER_data_InBUS;
          stateNext  = (CC_posDOWNCOUNTER_data_InBUS != zeroVal) ? stRun : stDone;
        end else if (posDOWNCOUNTER_AUTORELOAD && (shadowReg != zeroVal)) begin
          countNext = shadowReg;
          stateNext = stRun;
        end else begin
          stateNext = stIdle;
          countNext = zeroVal;
        end
      end

      default: begin
        stateNext = stIdle;
        countNext = zeroVal;
      end
    endcase
  end

  assign CC_posDOWNCOUNTER_data_OutBUS   = countReg;
  assign CC_posDOWNCOUNTER_T0_OutLow     = t0Reg;
  assign CC_posDOWNCOUNTER_busy_Out      = (stateReg == stRun);
  assign CC_posDOWNCOUNTER_done_OutPulse = (stateReg == stDone);

endmodule
